ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the shared PS2_CLK/PS2_DAT open-drain lines. It is the opposite direction to the existing keyboard receive path. It sits beside the receiver at the top level, and the top level ties each line low when the matching `*_oe` output is 1 and leaves it high-Z otherwise.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit time (100 µs at 50 MHz).
- START_TIMEOUT, 750000: maximum cycles from clock release to the device's first falling edge (15 ms).
- XFER_TIMEOUT, 100000: maximum cycles from the first falling edge to the acknowledge (2 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset; the top level drives it from KEY[0].
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE.
- tx_busy  out  1  high outside IDLE; the receiver ignores bytes while this is high.
- tx_done  out  1  one-cycle pulse when a byte completes with a valid acknowledge.
- tx_error  out  1  one-cycle pulse on timeout or missing acknowledge.
- ps2_clk_in  in  1  raw PS2_CLK pin value.
- ps2_dat_in  in  1  raw PS2_DAT pin value.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.

## Operation
- Both pin inputs pass through a 2-FF synchronizer. A falling edge (fall) is sync_clk 1→0 between consecutive cycles.
- Accept: in IDLE, tx_valid=1 latches tx_data into shreg and latches parity = ~^tx_data (odd parity).
- States and transitions:
  - IDLE → INHIBIT on accept.
  - INHIBIT: clk_oe=1, dat_oe=0. After INHIBIT_CYCLES cycles, set dat_oe=1 (start bit) → REQ.
  - REQ: clk_oe=1 and dat_oe=1 for exactly 1 cycle, then release the clock (clk_oe=0) → WAIT_CLK.
  - WAIT_CLK: on the first fall, dat_oe = ~shreg[0] (bit0), edge_cnt=1 → XFER. Timer expiry at START_TIMEOUT → ERR.
  - XFER, on each fall with edge_cnt incremented:
    - edges 2..8: dat_oe = ~bit[edge_cnt-1], LSB first.
    - edge 9: dat_oe = ~parity.
    - edge 10: dat_oe=0 (stop bit, line released).
    - edge 11: sample sync_dat. A 0 (acknowledge) goes → WAIT_IDLE; a 1 goes → ERR.
    - Timer expiry at XFER_TIMEOUT before edge 11 → ERR.
  - WAIT_IDLE: wait until sync_clk=1 and sync_dat=1, then pulse tx_done → IDLE. This wait shares the XFER timeout; expiry → ERR.
  - ERR: clk_oe=0, dat_oe=0, pulse tx_error for 1 cycle → IDLE.
- A single cycle counter is cleared on every state entry and on every fall in XFER, so XFER_TIMEOUT applies between consecutive edges.
- If a fall and timer expiry occur in the same cycle, the edge wins.
- tx_valid outside IDLE is ignored; it is neither queued nor latched.
- Falls seen in IDLE belong to the receiver and are ignored.
- edge_cnt is 4 bits wide and saturates at 11. The cycle counter is 20 bits wide.

## Timing
- Reset values: state=IDLE, clk_oe=0, dat_oe=0, tx_ready=1, tx_busy=0, tx_done=0, tx_error=0, shreg=0, edge_cnt=0.
- Reset asserted mid-transfer releases both lines asynchronously and returns to IDLE. No tx_error pulse is produced.
- Accept cycle N: clk_oe=1 from N+1. dat_oe rises at N+1+INHIBIT_CYCLES. clk_oe falls one cycle after that.
- Edge-to-drive latency: a pin falling edge updates dat_oe 3 cycles later (2 for sync, 1 for the register). This is well inside the device's clock-low half-period of at least 30 µs.
- tx_done and tx_error are registered and last exactly one cycle. tx_ready goes high in the same cycle as either pulse.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- ps2_pkg holds:
  - state enum: IDLE, INHIBIT, REQ, WAIT_CLK, XFER, WAIT_IDLE, ERR.
  - edge constants: LAST_DATA_EDGE=8, PARITY_EDGE=9, STOP_EDGE=10, ACK_EDGE=11.
  - default timing constants.
  - common scan codes for commands: CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF.
- Sub-module ps2_line_sync: 2-FF synchronizer plus registered falling-edge detect for PS2_CLK, with PS2_DAT synchronized alongside it. The receiver reuses it.

## Test plan
- Send 0xED, with a device model clocking at 12.5 kHz and acknowledging → data bits 1,0,1,1,0,1,1,1 LSB first, parity 1, stop 1; tx_done pulses once; both oe outputs are 0 afterwards.
- Send 0x01 → parity bit 0; clk_oe is held low for exactly 5000 cycles before dat_oe asserts.
- Device never clocks after release → tx_error pulses 750000 cycles after clk_oe drops; lines released; tx_ready=1.
- Device holds data high at edge 11 → tx_error pulses, no tx_done.
- resetn pulsed low during edge 5 → both oe outputs are 0 immediately, tx_busy=0; a following send of 0xF4 completes normally.
- tx_valid held high throughout the 0xED transfer with tx_data changed to 0x00 → the transmitted byte stays 0xED; a second transfer starts only after tx_ready returns.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit and keyboard receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StWaitClk,
    StXfer,
    StWaitIdle,
    StErr
  } state_e;

  localparam int unsigned LAST_DATA_EDGE = 8;
  localparam int unsigned PARITY_EDGE    = 9;
  localparam int unsigned STOP_EDGE      = 10;
  localparam int unsigned ACK_EDGE       = 11;

  localparam int unsigned DEFAULT_INHIBIT_CYCLES = 5000;
  localparam int unsigned DEFAULT_START_TIMEOUT  = 750000;
  localparam int unsigned DEFAULT_XFER_TIMEOUT   = 100000;

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned EDGE_W = 4;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for PS2_CLK/PS2_DAT with a registered PS2_CLK falling-edge strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic sync_clk,
  output logic sync_dat,
  output logic fall
);

  logic clk_meta;
  logic dat_meta;

  // Lines idle high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta <= 1'b1;
      sync_clk <= 1'b1;
      dat_meta <= 1'b1;
      sync_dat <= 1'b1;
      fall     <= 1'b0;
    end else begin
      clk_meta <= ps2_clk_in;
      sync_clk <= clk_meta;
      dat_meta <= ps2_dat_in;
      sync_dat <= dat_meta;
      fall     <= sync_clk & ~clk_meta;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
  parameter int unsigned START_TIMEOUT  = DEFAULT_START_TIMEOUT,
  parameter int unsigned XFER_TIMEOUT   = DEFAULT_XFER_TIMEOUT
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam logic [CNT_W-1:0] InhibitLast = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] StartLast   = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] XferLast    = CNT_W'(XFER_TIMEOUT - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [EDGE_W-1:0]   edge_cnt_q;
  logic [EDGE_W-1:0]   edge_nxt;
  logic [7:0]          shreg_q;
  logic                parity_q;
  logic                sync_clk;
  logic                sync_dat;
  logic                fall;

  ps2_line_sync u_sync (
    .clk        (CLOCK_50),
    .rst_n      (resetn),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .sync_clk   (sync_clk),
    .sync_dat   (sync_dat),
    .fall       (fall)
  );

  assign edge_nxt = (edge_cnt_q == EDGE_W'(ACK_EDGE)) ? edge_cnt_q : edge_cnt_q + 1'b1;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      cnt_q    <= cnt_q + 1'b1;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (tx_valid) begin
            shreg_q    <= tx_data;
            parity_q   <= odd_parity(tx_data);
            edge_cnt_q <= '0;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            state_q    <= StInhibit;
          end
        end
        StInhibit: begin
          if (cnt_q == InhibitLast) begin
            ps2_dat_oe <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StReq;
          end
        end
        StReq: begin
          ps2_clk_oe <= 1'b0;
          cnt_q      <= '0;
          state_q    <= StWaitClk;
        end
        StWaitClk: begin
          if (fall) begin
            ps2_dat_oe <= ~shreg_q[0];
            edge_cnt_q <= EDGE_W'(1);
            cnt_q      <= '0;
            state_q    <= StXfer;
          end else if (cnt_q == StartLast) begin
            ps2_dat_oe <= 1'b0;
            cnt_q      <= '0;
            state_q    <= StErr;
          end
        end
        StXfer: begin
          // An edge in the same cycle as expiry takes priority.
          if (fall) begin
            cnt_q      <= '0;
            edge_cnt_q <= edge_nxt;
            if (edge_nxt <= EDGE_W'(LAST_DATA_EDGE)) begin
              ps2_dat_oe <= ~shreg_q[edge_cnt_q[2:0]];
            end else if (edge_nxt == EDGE_W'(PARITY_EDGE)) begin
              ps2_dat_oe <= ~parity_q;
            end else if (edge_nxt == EDGE_W'(STOP_EDGE)) begin
              ps2_dat_oe <= 1'b0;
            end else if (!sync_dat) begin
              state_q <= StWaitIdle;
            end else begin
              ps2_dat_oe <= 1'b0;
              state_q    <= StErr;
            end
          end else if (cnt_q == XferLast) begin
            ps2_dat_oe <= 1'b0;
            cnt_q      <= '0;
            state_q    <= StErr;
          end
        end
        StWaitIdle: begin
          if (sync_clk && sync_dat) begin
            tx_done  <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            state_q  <= StIdle;
          end else if (cnt_q == XferLast) begin
            ps2_dat_oe <= 1'b0;
            cnt_q      <= '0;
            state_q    <= StErr;
          end
        end
        StErr: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          tx_error   <= 1'b1;
          tx_ready   <= 1'b1;
          tx_busy    <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 50;
  localparam int unsigned STO = 3000;
  localparam int unsigned XTO = 400;
  localparam int HP = 40;  // device clock half period in system cycles

  localparam int ModeAck   = 0;
  localparam int ModeNoClk = 1;
  localparam int ModeNoAck = 2;
  localparam int ModeAbort = 3;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       clk_line, dat_line;

  assign clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign dat_line = ~(ps2_dat_oe | dev_dat_low);

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .XFER_TIMEOUT   (XTO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       ok;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] cap_data;
  logic       cap_par, cap_stop;
  logic       prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per done/error pulse.
  always @(negedge CLOCK_50) begin : monitor
    exp_t e;
    if (prev_pulse) check("pulse_one_cycle", {30'd0, tx_done, tx_error}, 0);
    if (tx_done || tx_error) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, tx_done, tx_error}, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, tx_done, tx_error}, e.ok ? 2'b10 : 2'b01);
        check("ready_with_pulse", {31'd0, tx_ready}, 1);
        check("lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        if (e.ok) begin
          check("data_byte", {24'd0, cap_data}, {24'd0, e.data});
          check("parity_bit", {31'd0, cap_par}, {31'd0, e.par});
          check("stop_bit", {31'd0, cap_stop}, 1);
        end
      end
    end
    prev_pulse = tx_done | tx_error;
  end

  task automatic send(input logic [7:0] d);
    @(negedge CLOCK_50);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    check("busy_after_accept", {31'd0, tx_busy}, 1);
  endtask

  // Device: waits for the request-to-send, then clocks 11 edges, sampling on rising edges.
  task automatic dev_run(input int mode);
    logic [9:0] bits;
    int w;
    bits     = 'x;
    cap_data = 'x;
    cap_par  = 1'bx;
    cap_stop = 1'bx;
    w = 0;
    while (!(!ps2_clk_oe && ps2_dat_oe) && w < int'(INH) + 200) begin
      @(negedge CLOCK_50);
      w++;
    end
    check("request_to_send", {30'd0, ~ps2_clk_oe, ps2_dat_oe}, 2'b11);
    if (ps2_clk_oe || !ps2_dat_oe) return;
    if (mode == ModeNoClk) return;
    for (int e = 1; e <= 11; e++) begin
      if (e == 11 && mode == ModeAck) dev_dat_low = 1'b1;
      repeat (HP) @(negedge CLOCK_50);
      dev_clk_low = 1'b1;
      if (mode == ModeAbort && e == 5) begin
        repeat (6) @(negedge CLOCK_50);
        return;
      end
      repeat (HP) @(negedge CLOCK_50);
      if (e <= 10) bits[e-1] = dat_line;
      dev_clk_low = 1'b0;
    end
    dev_dat_low = 1'b0;
    cap_data = bits[7:0];
    cap_par  = bits[8];
    cap_stop = bits[9];
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < int'(XTO) * 4) begin
      @(negedge CLOCK_50);
      w++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("idle_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
  endtask

  initial begin : watchdog
    repeat (100000) @(posedge CLOCK_50);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int w;
    int lat;

    repeat (3) @(negedge CLOCK_50);
    check("reset_outputs", {26'd0, ps2_clk_oe, ps2_dat_oe, tx_ready, tx_busy, tx_done, tx_error},
          6'b001000);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // 0xED: bits 1,0,1,1,0,1,1,1 LSB first, parity 1.
    exp_q.push_back('{data: 8'hED, par: 1'b1, ok: 1'b1});
    send(CMD_SET_LEDS);
    dev_run(ModeAck);
    drain();

    // 0x01: parity 0, and the inhibit window length.
    exp_q.push_back('{data: 8'h01, par: 1'b0, ok: 1'b1});
    send(8'h01);
    w = 0;
    while (ps2_clk_oe && !ps2_dat_oe && w < int'(INH) + 20) begin
      w++;
      @(negedge CLOCK_50);
    end
    check("inhibit_cycles", w, INH);
    check("req_clk_still_low", {30'd0, ps2_clk_oe, ps2_dat_oe}, 2'b11);
    dev_run(ModeAck);
    drain();

    // Device never clocks: start timeout.
    exp_q.push_back('{data: 8'hF4, par: 1'b0, ok: 1'b0});
    send(CMD_ENABLE);
    w = 0;
    while (ps2_clk_oe && w < int'(INH) + 20) begin
      @(negedge CLOCK_50);
      w++;
    end
    lat = 0;
    while (!tx_error && lat < int'(STO) + 50) begin
      @(negedge CLOCK_50);
      lat++;
    end
    // Release-to-error includes the one-cycle error state.
    check("start_timeout_latency", (lat >= int'(STO) && lat <= int'(STO) + 1), 1);
    drain();
    check("ready_after_timeout", {31'd0, tx_ready}, 1);

    // No acknowledge at edge 11.
    exp_q.push_back('{data: 8'hFF, par: 1'b1, ok: 1'b0});
    send(CMD_RESET);
    dev_run(ModeNoAck);
    drain();

    // Reset during edge 5, then a clean 0xF4.
    send(8'h55);
    dev_run(ModeAbort);
    resetn = 1'b0;
    #1;
    check("abort_lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    check("abort_busy_ready", {30'd0, tx_busy, tx_ready}, 2'b01);
    @(negedge CLOCK_50);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    exp_q.push_back('{data: 8'hF4, par: 1'b0, ok: 1'b1});
    send(CMD_ENABLE);
    dev_run(ModeAck);
    drain();

    // tx_valid held high with tx_data changed after accept.
    exp_q.push_back('{data: 8'hED, par: 1'b1, ok: 1'b1});
    exp_q.push_back('{data: 8'h00, par: 1'b1, ok: 1'b1});
    @(negedge CLOCK_50);
    tx_data  = CMD_SET_LEDS;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_data = 8'h00;
    dev_run(ModeAck);
    w = 0;
    while (tx_busy && w < 200) begin
      @(negedge CLOCK_50);
      w++;
    end
    w = 0;
    while (!tx_busy && w < 10) begin
      @(negedge CLOCK_50);
      w++;
    end
    tx_valid = 1'b0;
    check("second_accept", {31'd0, tx_busy}, 1);
    dev_run(ModeAck);
    drain();

    repeat (5) @(negedge CLOCK_50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
